// File: rtl/hex_digit_feeder.sv
// Debug-display front end: captures a 32-bit word and presents one 16-bit half as four hex digit codes.
// Build option: define HEX_FREEZE_EN to enable the freeze key and the frozen (capture-inhibit) state.
module hex_digit_feeder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value_in,
  input  logic        value_valid,
  input  logic        page_key_n,
  input  logic        freeze_key_n,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic        page,
  output logic        frozen
);

`ifdef HEX_FREEZE_EN
  localparam int NKEYS = 2;
`else
  localparam int NKEYS = 1;
`endif

  logic [NKEYS-1:0] key_raw_n;
  logic [NKEYS-1:0] key_press;

  assign key_raw_n[0] = page_key_n;
`ifdef HEX_FREEZE_EN
  assign key_raw_n[1] = freeze_key_n;
`else
  logic unused_freeze_key_n;
  assign unused_freeze_key_n = freeze_key_n;
`endif

  // Per key: 2-flop synchronizer, debouncer, and a registered falling-edge detector on the debounced level.
  for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic             stable_seen_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_reg       <= 1'b1;
        sync2_reg       <= 1'b1;
        stable_reg      <= 1'b1;
        stable_seen_reg <= 1'b1;
        press_reg       <= 1'b0;
        cnt_reg         <= '0;
      end else begin
        sync1_reg       <= key_raw_n[gi];
        sync2_reg       <= sync1_reg;
        stable_seen_reg <= stable_reg;
        press_reg       <= stable_seen_reg & ~stable_reg;
        if (sync2_reg == stable_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_reg <= sync2_reg;
          cnt_reg    <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end

    assign key_press[gi] = press_reg;
  end

  logic [31:0] capture_reg;
  logic        page_reg;
  logic        frozen_int;

`ifdef HEX_FREEZE_EN
  logic frozen_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frozen_reg <= 1'b0;
    end else if (key_press[1]) begin
      frozen_reg <= ~frozen_reg;
    end
  end

  assign frozen_int = frozen_reg;
`else
  assign frozen_int = 1'b0;
`endif

  // Capture sees the pre-toggle frozen value, so a strobe on a freeze-event edge still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capture_reg <= '0;
      page_reg    <= 1'b0;
    end else begin
      if (value_valid && !frozen_int) begin
        capture_reg <= value_in;
      end
      if (key_press[0]) begin
        page_reg <= ~page_reg;
      end
    end
  end

  logic [15:0] shown_half;
  assign shown_half = page_reg ? capture_reg[31:16] : capture_reg[15:0];

  assign digit0 = shown_half[3:0];
  assign digit1 = shown_half[7:4];
  assign digit2 = shown_half[11:8];
  assign digit3 = shown_half[15:12];
  assign page   = page_reg;
  assign frozen = frozen_int;

endmodule

// File: tb/tb_hex_digit_feeder.sv
// Directed bench for hex_digit_feeder with DEBOUNCE_CYCLES=4; expectations adapt to the HEX_FREEZE_EN build.
module tb_hex_digit_feeder;

`ifdef HEX_FREEZE_EN
  localparam bit FRZ = 1'b1;
`else
  localparam bit FRZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] value_in;
  logic        value_valid;
  logic        page_key_n;
  logic        freeze_key_n;
  logic [3:0]  digit0, digit1, digit2, digit3;
  logic        page;
  logic        frozen;

  int checks = 0;
  int errors = 0;

  hex_digit_feeder #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .value_in     (value_in),
    .value_valid  (value_valid),
    .page_key_n   (page_key_n),
    .freeze_key_n (freeze_key_n),
    .digit0       (digit0),
    .digit1       (digit1),
    .digit2       (digit2),
    .digit3       (digit3),
    .page         (page),
    .frozen       (frozen)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] digits();
    return {16'h0, digit3, digit2, digit1, digit0};
  endfunction

  task automatic strobe(input logic [31:0] v);
    value_in    = v;
    value_valid = 1'b1;
    step(1);
    value_valid = 1'b0;
    value_in    = 32'hDEAD_0000;
  endtask

  task automatic press_freeze();
    freeze_key_n = 1'b0;
    step(10);
    freeze_key_n = 1'b1;
    step(10);
  endtask

  task automatic press_page();
    page_key_n = 1'b0;
    step(10);
    page_key_n = 1'b1;
    step(10);
  endtask

  initial begin
    rst_n        = 1'b0;
    value_in     = 32'h0;
    value_valid  = 1'b0;
    page_key_n   = 1'b1;
    freeze_key_n = 1'b1;
    #3;
    check("rst_digits", digits(), 32'h0000);
    check("rst_page", {31'b0, page}, 32'd0);
    check("rst_frozen", {31'b0, frozen}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(2);

    // Single capture, lower half shown.
    strobe(32'h1234ABCD);
    check("cap_digits", digits(), 32'hABCD);
    check("cap_page", {31'b0, page}, 32'd0);
    check("cap_frozen", {31'b0, frozen}, 32'd0);

    // Held page key: toggle exactly 7 edges after the first low sample, then no more.
    page_key_n = 1'b0;
    step(7);
    check("page_early", {31'b0, page}, 32'd0);
    step(1);
    check("page_toggle", {31'b0, page}, 32'd1);
    check("page_digits", digits(), 32'h1234);
    step(22);
    check("page_held", {31'b0, page}, 32'd1);
    page_key_n = 1'b1;
    step(10);
    check("page_release", {31'b0, page}, 32'd1);

    // Short glitch ignored.
    page_key_n = 1'b0;
    step(3);
    page_key_n = 1'b1;
    step(12);
    check("glitch_page", {31'b0, page}, 32'd1);

    // Freeze inhibits capture; second press re-enables.
    press_freeze();
    check("frz_on", {31'b0, frozen}, {31'b0, FRZ});
    strobe(32'hFFFF0000);
    check("frz_digits", digits(), FRZ ? 32'h1234 : 32'hFFFF);
    press_freeze();
    check("frz_off", {31'b0, frozen}, 32'd0);
    strobe(32'h55667788);
    check("unfrz_digits", digits(), 32'h5566);

    // Simultaneous page + freeze events, with a strobe on that same edge.
    page_key_n   = 1'b0;
    freeze_key_n = 1'b0;
    step(7);
    check("both_pre_page", {31'b0, page}, 32'd1);
    value_in    = 32'h0000BEEF;
    value_valid = 1'b1;
    step(1);
    value_valid = 1'b0;
    value_in    = 32'hDEAD_0000;
    check("both_page", {31'b0, page}, 32'd0);
    check("both_frozen", {31'b0, frozen}, {31'b0, FRZ});
    check("both_digits", digits(), 32'hBEEF);
    step(2);
    page_key_n   = 1'b1;
    freeze_key_n = 1'b1;
    step(10);

    strobe(32'h12345678);
    check("frz2_digits", digits(), FRZ ? 32'hBEEF : 32'h5678);

    // Set up page=1 with a nonzero capture, then reset mid-debounce.
    press_freeze();
    check("frz2_off", {31'b0, frozen}, 32'd0);
    strobe(32'hCAFEF00D);
    check("low_digits", digits(), 32'hF00D);
    press_page();
    check("hi_page", {31'b0, page}, 32'd1);
    check("hi_digits", digits(), 32'hCAFE);

    page_key_n = 1'b0;
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_digits", digits(), 32'h0000);
    check("mrst_page", {31'b0, page}, 32'd0);
    check("mrst_frozen", {31'b0, frozen}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Key still held: the debounce restarts from zero after reset.
    step(7);
    check("post_rst_early", {31'b0, page}, 32'd0);
    step(1);
    check("post_rst_page", {31'b0, page}, 32'd1);
    check("post_rst_dig", digits(), 32'h0000);
    page_key_n = 1'b1;
    step(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
